// File: rtl/busrq_responder.sv
// busrq_responder: hands the shared bus to an external master on request.
// The block drains any local access, leaves a turnaround gap, and then
// acknowledges. On release it leaves another gap before the local drivers
// are enabled again.
//
// Ports:
//   clk_fpga   - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   busrq_n    - external bus request, active low, asynchronous to clk_fpga
//   acc_start  - local master wants to start an access this cycle
//   acc_busy   - a local access is in flight
//   acc_gnt    - local access may start this cycle (combinational)
//   busak_n    - bus acknowledge to the external master, active low
//   bus_oe     - enable for the local address/data/control drivers
//   grant_cnt  - saturating count of grants issued
module busrq_responder #(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic       clk_fpga,
    input  logic       rst_n,
    input  logic       busrq_n,
    input  logic       acc_start,
    input  logic       acc_busy,
    output logic       acc_gnt,
    output logic       busak_n,
    output logic       bus_oe,
    output logic [7:0] grant_cnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned GCNT_W = 8;
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_OWN,
        ST_DRAIN,
        ST_TURN_OFF,
        ST_GRANTED,
        ST_TURN_ON
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GCNT_W-1:0]   grant_cnt_q, grant_cnt_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                bus_oe_q, bus_oe_d;
    logic                busak_n_q, busak_n_d;
    logic                rq_s;

    // Two-flop synchronizer for the asynchronous request; idles high.
    assign sync1_d = busrq_n;
    assign sync2_d = sync1_q;
    assign rq_s    = ~sync2_q;

    // A request seen this cycle blocks a new local start in the same cycle.
    assign acc_gnt = acc_start & (state_q == ST_OWN) & ~rq_s;

    // State, counters and registered outputs.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OWN;
            cnt_q       <= '0;
            grant_cnt_q <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            bus_oe_q    <= 1'b1;
            busak_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_cnt_q <= grant_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            bus_oe_q    <= bus_oe_d;
            busak_n_q   <= busak_n_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state and never overlap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_cnt_d = grant_cnt_q;

        unique case (state_q)
            ST_OWN: begin
                if (rq_s) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rq_s) begin
                    state_d = ST_OWN;
                end else if (!acc_busy) begin
                    state_d = ST_TURN_OFF;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_TURN_OFF: begin
                // Fixed-length gap; the request is not re-examined here.
                if (cnt_q == '0) begin
                    state_d = ST_GRANTED;
                    if (grant_cnt_q != '1) begin
                        grant_cnt_d = grant_cnt_q + GCNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GRANTED: begin
                if (!rq_s) begin
                    state_d = ST_TURN_ON;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_TURN_ON: begin
                // A renewed request cannot shorten the gap.
                if (cnt_q == '0) begin
                    state_d = ST_OWN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OWN;
            end
        endcase

        bus_oe_d  = (state_d == ST_OWN) || (state_d == ST_DRAIN);
        busak_n_d = (state_d != ST_GRANTED);
    end

    assign bus_oe    = bus_oe_q;
    assign busak_n   = busak_n_q;
    assign grant_cnt = grant_cnt_q;

endmodule
